// File: rtl/dest_pipe.sv
// Destination-register pipeline and hazard controller (EX -> IMD -> WB) for the 5-stage core.
// Latency: stage fields advance one stage per clk; stall/fwd_a/fwd_b are combinational, same cycle.
// Backpressure: stall holds PC and IF/ID and injects an EX bubble; flush overrides stall.
//
// Build option: define DEST_PIPE_FWD_EN for operand forwarding with a single load-use stall.
// Without it, forwarding is tied off and any RAW hazard against EX/IMD/WB stalls ID.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   id_valid, id_rd, id_regwrite,  instruction currently in ID (destination and flags)
//   id_memread
//   id_rn, id_rm, id_uses_rn,      ID source registers and whether each is read
//   id_uses_rm
//   flush                          branch taken: squash the ID instruction
//   stall                          hold PC and IF/ID, bubble into EX
//   fwd_a, fwd_b                   EX operand select: 00 regfile, 01 IMD result, 10 WB result
//   rd_imd, regwrite_imd           IMD destination and qualified write enable
//   rd_wb, regwrite_wb             WB destination and qualified write enable (regfile write port)
//   stall_count                    saturating count of stall cycles
module dest_pipe #(
  parameter int ZR_REG = 31,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [4:0]       rd_imd,
  output logic             regwrite_imd,
  output logic [4:0]       rd_wb,
  output logic             regwrite_wb,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [4:0] ZR = 5'(ZR_REG);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_IMD = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  // Destination view carried by IMD and WB.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regWrite;
    logic       memRead;
  } dstStage_t;

  // EX additionally keeps its sources so the forwarding muxes can be chosen.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regWrite;
    logic       memRead;
    logic [4:0] rn;
    logic [4:0] rm;
    logic       usesRn;
    logic       usesRm;
  } exStage_t;

  localparam dstStage_t DST_BUBBLE = '{valid: 1'b0, rd: ZR, regWrite: 1'b0, memRead: 1'b0};
  localparam exStage_t  EX_BUBBLE  = '{valid: 1'b0, rd: ZR, regWrite: 1'b0, memRead: 1'b0,
                                       rn: ZR, rm: ZR, usesRn: 1'b0, usesRm: 1'b0};

  exStage_t   exQ;
  exStage_t   exD;
  dstStage_t  imdQ;
  dstStage_t  wbQ;
  logic [CNT_W-1:0] stallCnt;

  logic exWe;
  logic imdWe;
  logic wbWe;
  logic hazard;
  logic issue;
  logic [1:0] fwdA;
  logic [1:0] fwdB;

  // True when a used ID source names the given destination.
  function automatic logic idReads(input logic [4:0] rd,
                                   input logic       usesRn, input logic [4:0] rn,
                                   input logic       usesRm, input logic [4:0] rm);
    return (usesRn && (rn == rd)) || (usesRm && (rm == rd));
  endfunction

  // A stage only counts as a writer when it is real, writes, and does not target the zero register.
  // Every comparison below goes through these, so the zero register can never forward or stall.
  assign exWe  = exQ.valid  && exQ.regWrite  && (exQ.rd  != ZR);
  assign imdWe = imdQ.valid && imdQ.regWrite && (imdQ.rd != ZR);
  assign wbWe  = wbQ.valid  && wbQ.regWrite  && (wbQ.rd  != ZR);

`ifdef DEST_PIPE_FWD_EN
  // Only a load in EX cannot be covered: its data exists one stage later. One bubble moves it to
  // IMD, and by the time the consumer sits in EX the load is in WB and forwards from there.
  assign hazard = exQ.memRead && exWe &&
                  idReads(exQ.rd, id_uses_rn, id_rn, id_uses_rm, id_rm);
`else
  // No bypass paths: wait until the producer has left WB. The regfile is not write-through,
  // so a producer in WB still blocks for that cycle.
  assign hazard = (exWe  && idReads(exQ.rd,  id_uses_rn, id_rn, id_uses_rm, id_rm)) ||
                  (imdWe && idReads(imdQ.rd, id_uses_rn, id_rn, id_uses_rm, id_rm)) ||
                  (wbWe  && idReads(wbQ.rd,  id_uses_rn, id_rn, id_uses_rm, id_rm));
`endif

  // flush wins: the ID instruction is being discarded, so holding it would be pointless.
  assign stall = id_valid && !flush && hazard;
  assign issue = id_valid && !flush && !stall;

  always_comb begin
    fwdA = SEL_RF;
    fwdB = SEL_RF;
`ifdef DEST_PIPE_FWD_EN
    // IMD is checked first: it holds the younger write to the same register.
    if (exQ.usesRn && (exQ.rn != ZR)) begin
      if (imdWe && (imdQ.rd == exQ.rn)) begin
        fwdA = SEL_IMD;
      end else if (wbWe && (wbQ.rd == exQ.rn)) begin
        fwdA = SEL_WB;
      end
    end
    if (exQ.usesRm && (exQ.rm != ZR)) begin
      if (imdWe && (imdQ.rd == exQ.rm)) begin
        fwdB = SEL_IMD;
      end else if (wbWe && (wbQ.rd == exQ.rm)) begin
        fwdB = SEL_WB;
      end
    end
`endif
  end

  always_comb begin
    exD = EX_BUBBLE;
    if (issue) begin
      exD.valid    = 1'b1;
      exD.rd       = id_rd;
      exD.regWrite = id_regwrite;
      exD.memRead  = id_memread;
      exD.rn       = id_rn;
      exD.rm       = id_rm;
      exD.usesRn   = id_uses_rn;
      exD.usesRm   = id_uses_rm;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exQ      <= EX_BUBBLE;
      imdQ     <= DST_BUBBLE;
      wbQ      <= DST_BUBBLE;
      stallCnt <= '0;
    end else begin
      exQ  <= exD;
      imdQ <= '{valid: exQ.valid, rd: exQ.rd, regWrite: exQ.regWrite, memRead: exQ.memRead};
      wbQ  <= imdQ;
      if (stall && (stallCnt != {CNT_W{1'b1}})) begin
        stallCnt <= stallCnt + CNT_W'(1);
      end
    end
  end

  // memRead travels with IMD/WB for the memory stage's benefit but no decision here reads it
  // past EX; the source fields in EX are only consulted when forwarding is built in.
  logic unusedBits;
`ifdef DEST_PIPE_FWD_EN
  assign unusedBits = ^{imdQ.memRead, wbQ.memRead};
`else
  assign unusedBits = ^{exQ.memRead, imdQ.memRead, wbQ.memRead,
                        exQ.rn, exQ.rm, exQ.usesRn, exQ.usesRm};
`endif

  assign fwd_a        = fwdA;
  assign fwd_b        = fwdB;
  assign rd_imd       = imdQ.rd;
  assign regwrite_imd = imdWe;
  assign rd_wb        = wbQ.rd;
  assign regwrite_wb  = wbWe;
  assign stall_count  = stallCnt;

endmodule

// File: tb/tb_dest_pipe.sv
module tb_dest_pipe;

  localparam int CW = 3;
  localparam logic [4:0] ZR = 5'd31;
`ifdef DEST_PIPE_FWD_EN
  localparam int SPR   = 1;  // stall cycles for a dependency on the instruction just ahead
  localparam int WBSEL = 2;  // select seen when a consumer's producer sits in WB
`else
  localparam int SPR   = 3;
  localparam int WBSEL = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic id_valid, id_regwrite, id_memread, id_uses_rn, id_uses_rm, flush;
  logic [4:0] id_rd, id_rn, id_rm;
  logic stall;
  logic [1:0] fwd_a, fwd_b;
  logic [4:0] rd_imd, rd_wb;
  logic regwrite_imd, regwrite_wb;
  logic [CW-1:0] stall_count;

  dest_pipe #(.ZR_REG(31), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .rd_imd(rd_imd), .regwrite_imd(regwrite_imd), .rd_wb(rd_wb), .regwrite_wb(regwrite_wb),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic [4:0] rn;
    logic       un;
    logic [4:0] rm;
    logic       um;
    logic       fl;
    logic       xStall;
    logic [1:0] xFa;
    logic [1:0] xFb;
  } vec_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       rw;
  } sbEnt_t;

  // Scoreboard holds expected {WB, IMD, EX} contents, oldest first.
  sbEnt_t sb[$];
  vec_t   tbl[$];
  int     nTests = 0;
  int     nFail  = 0;
  int     expCnt = 0;
  int     cyc    = 0;
  vec_t   ld, co, nop, prod, cons;

  function automatic vec_t mk(input int vld, rd, rw, mr, rn, un, rm, um, fl, st, fa, fb);
    vec_t v;
    v.vld = vld[0]; v.rd = rd[4:0]; v.rw = rw[0]; v.mr = mr[0];
    v.rn = rn[4:0]; v.un = un[0]; v.rm = rm[4:0]; v.um = um[0]; v.fl = fl[0];
    v.xStall = st[0]; v.xFa = fa[1:0]; v.xFb = fb[1:0];
    return v;
  endfunction

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.vld; id_rd = v.rd; id_regwrite = v.rw; id_memread = v.mr;
    id_rn = v.rn; id_uses_rn = v.un; id_rm = v.rm; id_uses_rm = v.um; flush = v.fl;
  endtask

  task automatic sbInit();
    sbEnt_t b;
    b.rd = ZR; b.rw = 1'b0;
    sb.delete();
    repeat (3) sb.push_back(b);
    expCnt = 0;
  endtask

  task automatic chkReset();
    cmp("rst stall", 16'(stall), 16'(0));
    cmp("rst fwd_a", 16'(fwd_a), 16'(0));
    cmp("rst fwd_b", 16'(fwd_b), 16'(0));
    cmp("rst rd_imd", 16'(rd_imd), 16'(ZR));
    cmp("rst rd_wb", 16'(rd_wb), 16'(ZR));
    cmp("rst regwrite_imd", 16'(regwrite_imd), 16'(0));
    cmp("rst regwrite_wb", 16'(regwrite_wb), 16'(0));
    cmp("rst stall_count", 16'(stall_count), 16'(0));
  endtask

  // Drive one ID slot at the falling edge and check everything visible in that cycle.
  task automatic check(input vec_t v);
    sbEnt_t wbE, imdE;
    @(negedge clk);
    drive(v);
    #2;
    cmp("stall", 16'(stall), 16'(v.xStall));
    cmp("fwd_a", 16'(fwd_a), 16'(v.xFa));
    cmp("fwd_b", 16'(fwd_b), 16'(v.xFb));
    cmp("stall_count", 16'(stall_count), 16'(expCnt));
    wbE  = sb.pop_front();
    imdE = sb[0];
    cmp("rd_wb", 16'(rd_wb), 16'(wbE.rd));
    cmp("regwrite_wb", 16'(regwrite_wb), 16'(wbE.rw));
    cmp("rd_imd", 16'(rd_imd), 16'(imdE.rd));
    cmp("regwrite_imd", 16'(regwrite_imd), 16'(imdE.rw));
  endtask

  // Clock edge: whatever left ID (instruction or bubble) enters the scoreboard.
  task automatic adv(input vec_t v);
    sbEnt_t e;
    @(posedge clk);
    if (v.vld && !v.fl && !v.xStall) begin
      e.rd = v.rd;
      e.rw = v.rw && (v.rd != ZR);
    end else begin
      e.rd = ZR;
      e.rw = 1'b0;
    end
    sb.push_back(e);
    if (v.xStall && expCnt != (1 << CW) - 1) expCnt++;
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    nop = mk(0,0,0,0, 0,0,0,0, 0, 0,0,0);
    reset = 1'b1;
    drive(nop);
    #3;
    chkReset();
    @(posedge clk);
    #1 reset = 1'b0;
    sbInit();

    //            vld rd rw mr  rn un rm um fl  stall fa fb
`ifdef DEST_PIPE_FWD_EN
    tbl.push_back(mk(1, 1,1,0,  0,0, 0,0, 0,  0,0,0));  // producer rd=1
    tbl.push_back(mk(1, 6,1,0,  1,1, 0,0, 0,  0,0,0));  // consumer rn=1, back-to-back
    tbl.push_back(mk(0, 0,0,0,  0,0, 0,0, 0,  0,1,0));  // consumer in EX: IMD forward
    tbl.push_back(mk(1, 2,1,0,  0,0, 0,0, 0,  0,0,0));  // producer rd=2
    tbl.push_back(mk(1, 7,1,0,  0,0, 0,0, 0,  0,0,0));  // spacer
    tbl.push_back(mk(1, 8,1,0,  0,0, 2,1, 0,  0,0,0));  // consumer rm=2
    tbl.push_back(mk(0, 0,0,0,  0,0, 0,0, 0,  0,0,2));  // WB forward on B
    tbl.push_back(mk(1, 5,1,0,  0,0, 0,0, 0,  0,0,0));  // rd=5 (older)
    tbl.push_back(mk(1, 5,1,0,  0,0, 0,0, 0,  0,0,0));  // rd=5 (younger)
    tbl.push_back(mk(1, 9,1,0,  5,1, 0,0, 0,  0,0,0));  // consumer rn=5
    tbl.push_back(mk(0, 0,0,0,  0,0, 0,0, 0,  0,1,0));  // IMD wins over WB
    tbl.push_back(mk(1, 4,1,1,  0,0, 0,0, 0,  0,0,0));  // load rd=4
    tbl.push_back(mk(1,10,1,0,  4,1, 0,0, 0,  1,0,0));  // load-use: stall
    tbl.push_back(mk(1,10,1,0,  4,1, 0,0, 0,  0,0,0));  // held consumer issues
    tbl.push_back(mk(0, 0,0,0,  0,0, 0,0, 0,  0,2,0));  // load reaches consumer via WB
    tbl.push_back(mk(1,31,1,0,  0,0, 0,0, 0,  0,0,0));  // write to zero register
    tbl.push_back(mk(1,11,1,0, 31,1, 0,0, 0,  0,0,0));  // consumer rn=31
    tbl.push_back(mk(0, 0,0,0,  0,0, 0,0, 0,  0,0,0));  // no forward from r31
    tbl.push_back(mk(1,12,1,1,  0,0, 0,0, 0,  0,0,0));  // load rd=12
    tbl.push_back(mk(1,13,1,0, 12,1, 0,0, 1,  0,0,0));  // load-use with flush
    tbl.push_back(mk(0, 0,0,0,  0,0, 0,0, 0,  0,0,0));
    tbl.push_back(mk(0, 0,0,0,  0,0, 0,0, 0,  0,0,0));
    tbl.push_back(mk(0, 0,0,0,  0,0, 0,0, 0,  0,0,0));
`else
    tbl.push_back(mk(1, 3,1,0,  0,0, 0,0, 0,  0,0,0));  // producer rd=3 (not a load)
    tbl.push_back(mk(1, 6,1,0,  3,1, 0,0, 0,  1,0,0));  // producer in EX
    tbl.push_back(mk(1, 6,1,0,  3,1, 0,0, 0,  1,0,0));  // producer in IMD
    tbl.push_back(mk(1, 6,1,0,  3,1, 0,0, 0,  1,0,0));  // producer in WB
    tbl.push_back(mk(1, 6,1,0,  3,1, 0,0, 0,  0,0,0));  // producer gone: issue
    tbl.push_back(mk(0, 0,0,0,  0,0, 0,0, 0,  0,0,0));  // consumer in EX, fwd tied off
    tbl.push_back(mk(1,31,1,0,  0,0, 0,0, 0,  0,0,0));  // write to zero register
    tbl.push_back(mk(1,14,1,0, 31,1, 0,0, 0,  0,0,0));  // consumer rn=31: no stall
    tbl.push_back(mk(0, 0,0,0,  0,0, 0,0, 0,  0,0,0));
    tbl.push_back(mk(1,15,1,0,  0,0, 0,0, 0,  0,0,0));  // producer rd=15
    tbl.push_back(mk(1,16,1,0,  0,0,15,1, 1,  0,0,0));  // hazard with flush
    tbl.push_back(mk(0, 0,0,0,  0,0, 0,0, 0,  0,0,0));
    tbl.push_back(mk(0, 0,0,0,  0,0, 0,0, 0,  0,0,0));
    tbl.push_back(mk(0, 0,0,0,  0,0, 0,0, 0,  0,0,0));
`endif
    foreach (tbl[i]) begin
      check(tbl[i]);
      adv(tbl[i]);
    end

    // Repeated load-use pairs drive the narrow stall counter into saturation.
    for (int r = 0; r < 8; r++) begin
      ld = mk(1,4,1,1, 0,0,0,0, 0, 0, (r > 0) ? WBSEL : 0, 0);
      check(ld);
      adv(ld);
      for (int k = 0; k <= SPR; k++) begin
        co = mk(1,10,1,0, 4,1,0,0, 0, (k < SPR) ? 1 : 0, 0, 0);
        check(co);
        adv(co);
      end
    end
    co = mk(0,0,0,0, 0,0,0,0, 0, 0, WBSEL, 0);
    check(co); adv(co);
    check(nop); adv(nop);
    check(nop); adv(nop);

    // Reset arriving in the middle of a stall.
    prod = mk(1, 4,1,1, 0,0,0,0, 0, 0,0,0);
    cons = mk(1,10,1,0, 4,1,0,0, 0, 1,0,0);
    check(prod); adv(prod);
    check(cons);
`ifndef DEST_PIPE_FWD_EN
    adv(cons);
    check(cons);
`endif
    #1 reset = 1'b1;
    #1 chkReset();
    @(posedge clk);
    #1 reset = 1'b0;
    sbInit();
    cons.xStall = 1'b0;
    check(cons); adv(cons);
    check(nop); adv(nop);
    check(nop); adv(nop);
    check(nop); adv(nop);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
